// File: rtl/user_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : user_timer_ctrl_pkg
//  Description : Shared types and constants for the user-domain timer slot.
//                Provides the OBI request/response structs, register
//                offsets, CTRL bit indices, the CTRL register struct and
//                a byte-enable merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package user_timer_ctrl_pkg;

    localparam int AID_W = 4;

    typedef struct packed {
        logic [31:0]      addr;
        logic             we;
        logic [3:0]       be;
        logic [31:0]      wdata;
        logic [AID_W-1:0] aid;
    } obi_a_t;

    typedef struct packed {
        logic   req;
        obi_a_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0]      rdata;
        logic [AID_W-1:0] rid;
        logic             err;
    } obi_r_t;

    typedef struct packed {
        logic   gnt;
        logic   rvalid;
        obi_r_t r;
    } obi_rsp_t;

    // Register offsets inside the 4 KiB window
    localparam logic [11:0] USER_TIMER_CTRL_OFFSET    = 12'h000;
    localparam logic [11:0] USER_TIMER_COUNT_OFFSET   = 12'h004;
    localparam logic [11:0] USER_TIMER_COMPARE_OFFSET = 12'h008;
    localparam logic [11:0] USER_TIMER_STATUS_OFFSET  = 12'h00C;

    // CTRL bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_RELOAD_BIT = 1;
    localparam int CTRL_IRQEN_BIT  = 2;
    localparam int CTRL_PRESC_LSB  = 8;
    localparam int STATUS_PEND_BIT = 0;

    typedef struct packed {
        logic [7:0] presc;
        logic       irqen;
        logic       reload;
        logic       en;
    } user_timer_ctrl_t;

    // CTRL as seen on the bus; unimplemented bits read as zero
    function automatic logic [31:0] ctrl_to_word(input user_timer_ctrl_t c);
        logic [31:0] w;
        w                            = '0;
        w[CTRL_EN_BIT]               = c.en;
        w[CTRL_RELOAD_BIT]           = c.reload;
        w[CTRL_IRQEN_BIT]            = c.irqen;
        w[CTRL_PRESC_LSB +: 8]       = c.presc;
        return w;
    endfunction

    // Replace only the bytes whose enable is set
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/user_timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : user_timer_core
//  Description : Prescaler, 32-bit up-counter and compare-match logic.
//  Ports       : clk_i, rst_ni     - clock, synchronous active-low reset
//                en, reload, presc - live CTRL fields
//                presc_clr         - restart prescaler (CTRL was written)
//                cmp               - compare value
//                count_we/wdata    - software write port for COUNT
//                count             - current counter value
//                match_pulse       - one cycle: tick with COUNT==cmp
//                oneshot_clr       - one cycle: match in one-shot mode
//  Revision    : 1.0 - initial release
// ============================================================================
module user_timer_core #(
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en,
    input  logic               reload,
    input  logic [PRESC_W-1:0] presc,
    input  logic               presc_clr,
    input  logic [31:0]        cmp,
    input  logic               count_we,
    input  logic [31:0]        count_wdata,
    output logic [31:0]        count,
    output logic               match_pulse,
    output logic               oneshot_clr
);

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [31:0]        r_count;
    logic               w_tick;
    logic               w_match;

    assign w_tick      = en && (r_presc_cnt == presc);
    assign w_match     = w_tick && (r_count == cmp);
    assign match_pulse = w_match;
    assign oneshot_clr = w_match && !reload;
    assign count       = r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_presc_cnt <= '0;
        end else if (presc_clr || !en || w_tick) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
        end
    end

    // Software write wins over the tick update in the same cycle.
    // On a one-shot match the counter simply holds its value.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (count_we) begin
            r_count <= count_wdata;
        end else if (w_match) begin
            if (reload) r_count <= '0;
        end else if (w_tick) begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/user_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : user_timer_ctrl
//  Description : OBI subordinate for the user-domain timer slot. Decodes the
//                register file (CTRL/COUNT/COMPARE/STATUS), drives a
//                single-cycle registered response and the level interrupt.
//  Ports       : clk_i     - clock
//                rst_ni    - synchronous active-low reset
//                obi_req_i - OBI request from the user demux
//                obi_rsp_o - OBI response (gnt comb, rest registered)
//                irq_o     - high while STATUS.PEND and CTRL.IRQEN
//  Revision    : 1.0 - initial release
// ============================================================================
module user_timer_ctrl
    import user_timer_ctrl_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);

    logic [9:0]       w_off;
    logic             w_req;
    logic             w_wr;
    logic             w_sel_ctrl, w_sel_count, w_sel_cmp, w_sel_status, w_hit;
    logic             w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_status;
    logic             w_pend_clr;
    logic [31:0]      w_rdata;
    logic [31:0]      w_count;
    logic             w_match;
    logic             w_oneshot_clr;
    user_timer_ctrl_t w_ctrl_next;
    user_timer_ctrl_t r_ctrl;
    logic [31:0]      r_cmp;
    logic             r_pend;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic [AID_W-1:0] r_rid;
    logic             r_err;
    logic             w_unused_addr;

    // Only the word offset inside the 4 KiB window takes part in decode
    assign w_unused_addr = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0]};

    assign w_off        = obi_req_i.a.addr[11:2];
    assign w_req        = obi_req_i.req;
    assign w_wr         = w_req && obi_req_i.a.we;
    assign w_sel_ctrl   = (w_off == USER_TIMER_CTRL_OFFSET[11:2]);
    assign w_sel_count  = (w_off == USER_TIMER_COUNT_OFFSET[11:2]);
    assign w_sel_cmp    = (w_off == USER_TIMER_COMPARE_OFFSET[11:2]);
    assign w_sel_status = (w_off == USER_TIMER_STATUS_OFFSET[11:2]);
    assign w_hit        = w_sel_ctrl || w_sel_count || w_sel_cmp || w_sel_status;
    assign w_wr_ctrl    = w_wr && w_sel_ctrl;
    assign w_wr_count   = w_wr && w_sel_count && (|obi_req_i.a.be);
    assign w_wr_cmp     = w_wr && w_sel_cmp;
    assign w_wr_status  = w_wr && w_sel_status;
    assign w_pend_clr   = w_wr_status && obi_req_i.a.be[0] &&
                          obi_req_i.a.wdata[STATUS_PEND_BIT];

    user_timer_core #(
        .PRESC_W (PRESC_W)
    ) u_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en          (r_ctrl.en),
        .reload      (r_ctrl.reload),
        .presc       (r_ctrl.presc[PRESC_W-1:0]),
        .presc_clr   (w_wr_ctrl),
        .cmp         (r_cmp),
        .count_we    (w_wr_count),
        .count_wdata (be_merge(w_count, obi_req_i.a.wdata, obi_req_i.a.be)),
        .count       (w_count),
        .match_pulse (w_match),
        .oneshot_clr (w_oneshot_clr)
    );

    // One-shot auto-clear is applied first so that a same-cycle software
    // write to the EN byte overrides it.
    always_comb begin
        w_ctrl_next = r_ctrl;
        if (w_oneshot_clr) w_ctrl_next.en = 1'b0;
        if (w_wr_ctrl) begin
            if (obi_req_i.a.be[0]) begin
                w_ctrl_next.en     = obi_req_i.a.wdata[CTRL_EN_BIT];
                w_ctrl_next.reload = obi_req_i.a.wdata[CTRL_RELOAD_BIT];
                w_ctrl_next.irqen  = obi_req_i.a.wdata[CTRL_IRQEN_BIT];
            end
            if (obi_req_i.a.be[1]) begin
                w_ctrl_next.presc  = obi_req_i.a.wdata[CTRL_PRESC_LSB +: 8];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_ctrl)   w_rdata = ctrl_to_word(r_ctrl);
        if (w_sel_count)  w_rdata = w_count;
        if (w_sel_cmp)    w_rdata = r_cmp;
        if (w_sel_status) w_rdata = {31'd0, r_pend};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ctrl <= '0;
            r_cmp  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_ctrl <= w_ctrl_next;
            if (w_wr_cmp) r_cmp <= be_merge(r_cmp, obi_req_i.a.wdata, obi_req_i.a.be);
            // A match in the same cycle as a W1C keeps PEND set
            r_pend <= w_match || (r_pend && !w_pend_clr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_req;
            r_rid    <= w_req ? obi_req_i.a.aid : '0;
            r_err    <= w_req && !w_hit;
            r_rdata  <= (w_req && !obi_req_i.a.we && w_hit) ? w_rdata : '0;
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = w_req;
        obi_rsp_o.rvalid  = r_rvalid;
        obi_rsp_o.r.rdata = r_rdata;
        obi_rsp_o.r.rid   = r_rid;
        obi_rsp_o.r.err   = r_err;
    end

    assign irq_o = r_pend && r_ctrl.irqen;

endmodule
`default_nettype wire

// File: tb/tb_user_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_user_timer_ctrl
//  Description : Self-checking bench for user_timer_ctrl: a table of single
//                bus accesses followed by hand-written timing sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_user_timer_ctrl;
    import user_timer_ctrl_pkg::*;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic     clk = 1'b0;
    logic     rst_n;
    obi_req_t req_s;
    obi_rsp_t rsp_s;
    logic     irq;
    int       cyc = 0;
    int       total = 0;
    int       bad = 0;
    logic [AID_W-1:0] aid_ctr = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    user_timer_ctrl #(.PRESC_W(8)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .obi_req_i (req_s),
        .obi_rsp_o (rsp_s),
        .irq_o     (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access: called just after a rising edge, returns just after the
    // edge that produced the response.
    task automatic bus(input logic [11:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [AID_W-1:0] aid;
        aid             = aid_ctr;
        req_s.req       = 1'b1;
        req_s.a.addr    = {20'h0, a};
        req_s.a.we      = we;
        req_s.a.be      = be;
        req_s.a.wdata   = wd;
        req_s.a.aid     = aid;
        #1;
        chk("gnt", {31'd0, rsp_s.gnt}, 32'd1);
        @(posedge clk); #1;
        req_s.req  = 1'b0;
        req_s.a.we = 1'b0;
        chk("rvalid", {31'd0, rsp_s.rvalid}, 32'd1);
        chk("rid", {28'd0, rsp_s.r.rid}, {28'd0, aid});
        rd      = rsp_s.r.rdata;
        er      = rsp_s.r.err;
        aid_ctr = aid_ctr + 1'b1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        er;
        bus(a, 1'b1, 4'hF, d, rd, er);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        bus(a, 1'b0, 4'hF, 32'h0, rd, er);
        chk(name, rd, exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Waits for irq to rise; returns cycles since t0, or -1 on timeout
    task automatic wait_irq(input int t0, input int limit, output int delta);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        delta = (irq === 1'b1) ? (cyc - t0) : -1;
    endtask

    function automatic vec_t mk(input logic [11:0] a, input logic we, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] er_d, input logic ee);
        vec_t v;
        v.addr = a; v.we = we; v.be = be; v.wdata = wd; v.exp_rdata = er_d; v.exp_err = ee;
        return v;
    endfunction

    vec_t vec [21];

    initial begin
        int          t0;
        int          d;
        logic [31:0] rd;
        logic        er;

        req_s = '0;
        rst_n = 1'b0;

        vec[0]  = mk(12'h000, 1'b0, 4'hF, 32'h0,          32'h0,          1'b0);
        vec[1]  = mk(12'h004, 1'b0, 4'hF, 32'h0,          32'h0,          1'b0);
        vec[2]  = mk(12'h008, 1'b0, 4'hF, 32'h0,          32'h0,          1'b0);
        vec[3]  = mk(12'h00C, 1'b0, 4'hF, 32'h0,          32'h0,          1'b0);
        vec[4]  = mk(12'h008, 1'b1, 4'hF, 32'hA5A5_5A5A,  32'h0,          1'b0);
        vec[5]  = mk(12'h008, 1'b0, 4'hF, 32'h0,          32'hA5A5_5A5A,  1'b0);
        vec[6]  = mk(12'h008, 1'b1, 4'h1, 32'h1122_3344,  32'h0,          1'b0);
        vec[7]  = mk(12'h00B, 1'b0, 4'hF, 32'h0,          32'hA5A5_5A44,  1'b0);
        vec[8]  = mk(12'h000, 1'b1, 4'h2, 32'hFFFF_FFFF,  32'h0,          1'b0);
        vec[9]  = mk(12'h000, 1'b0, 4'hF, 32'h0,          32'h0000_FF00,  1'b0);
        vec[10] = mk(12'h000, 1'b1, 4'hF, 32'h0,          32'h0,          1'b0);
        vec[11] = mk(12'h010, 1'b0, 4'hF, 32'h0,          32'h0,          1'b1);
        vec[12] = mk(12'hFFC, 1'b1, 4'hF, 32'hDEAD_BEEF,  32'h0,          1'b1);
        vec[13] = mk(12'hFFC, 1'b0, 4'hF, 32'h0,          32'h0,          1'b1);
        vec[14] = mk(12'h010, 1'b1, 4'hF, 32'h0,          32'h0,          1'b1);
        vec[15] = mk(12'h008, 1'b0, 4'hF, 32'h0,          32'hA5A5_5A44,  1'b0);
        vec[16] = mk(12'h00C, 1'b1, 4'hF, 32'hFFFF_FFFF,  32'h0,          1'b0);
        vec[17] = mk(12'h00C, 1'b0, 4'hF, 32'h0,          32'h0,          1'b0);
        vec[18] = mk(12'h004, 1'b1, 4'hC, 32'h1234_5678,  32'h0,          1'b0);
        vec[19] = mk(12'h004, 1'b0, 4'hF, 32'h0,          32'h1234_0000,  1'b0);
        vec[20] = mk(12'h004, 1'b1, 4'hF, 32'h0,          32'h0,          1'b0);

        // Reset state
        idle(2);
        chk("reset_rvalid", {31'd0, rsp_s.rvalid}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_rdata", rsp_s.r.rdata, 32'd0);
        rst_n = 1'b1;

        // Table of single accesses
        for (int i = 0; i < 21; i++) begin
            bus(vec[i].addr, vec[i].we, vec[i].be, vec[i].wdata, rd, er);
            if (!vec[i].we) chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vec[i].exp_err});
        end

        // Auto-reload: PRESC=3, COMPARE=5 -> match every 24 cycles
        do_reset();
        wr(12'h008, 32'd5);
        wr(12'h000, 32'h0000_0307);
        t0 = cyc;
        wait_irq(t0, 60, d);
        chk("reload_first_match", d, 32'd24);
        rd_chk("reload_count_zero", 12'h004, 32'd0);
        wr(12'h00C, 32'd1);
        chk("reload_irq_cleared", {31'd0, irq}, 32'd0);
        wait_irq(t0, 60, d);
        chk("reload_second_match", d, 32'd48);

        // One-shot: COMPARE=2, PRESC=0, IRQEN
        do_reset();
        wr(12'h008, 32'd2);
        wr(12'h000, 32'h0000_0005);
        t0 = cyc;
        wait_irq(t0, 20, d);
        chk("oneshot_match", d, 32'd3);
        rd_chk("oneshot_en_clear", 12'h000, 32'h0000_0004);
        rd_chk("oneshot_count", 12'h004, 32'd2);
        idle(3);
        rd_chk("oneshot_count_held", 12'h004, 32'd2);
        wr(12'h00C, 32'd1);
        chk("oneshot_w1c_irq", {31'd0, irq}, 32'd0);

        // Wrap: no PEND on 0xFFFFFFFF->0, PEND when COUNT reaches 1
        do_reset();
        wr(12'h008, 32'd1);
        wr(12'h004, 32'hFFFF_FFFE);
        wr(12'h000, 32'h0000_0001);
        rd_chk("wrap_status0", 12'h00C, 32'd0);
        rd_chk("wrap_count_max", 12'h004, 32'hFFFF_FFFF);
        rd_chk("wrap_status_after_wrap", 12'h00C, 32'd0);
        rd_chk("wrap_count_one", 12'h004, 32'd1);
        rd_chk("wrap_status_match", 12'h00C, 32'd1);
        rd_chk("wrap_count_held", 12'h004, 32'd1);

        // W1C in the same cycle as the match tick: PEND stays set
        do_reset();
        wr(12'h008, 32'd2);
        wr(12'h000, 32'h0000_0001);
        idle(2);
        wr(12'h00C, 32'd1);
        rd_chk("w1c_vs_match", 12'h00C, 32'd1);

        // COUNT write in the same cycle as a tick wins
        do_reset();
        wr(12'h008, 32'd100);
        wr(12'h000, 32'h0000_0001);
        wr(12'h004, 32'h0000_0010);
        rd_chk("count_write_vs_tick", 12'h004, 32'h0000_0010);

        // Reset with a request in flight drops the response
        req_s.req    = 1'b1;
        req_s.a.addr = 32'h0;
        req_s.a.we   = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        chk("reset_drops_rvalid", {31'd0, rsp_s.rvalid}, 32'd0);
        req_s.req = 1'b0;
        rst_n     = 1'b1;
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
